// File: rtl/mor1kx_spr_sys_unit_if.sv
// SPR bus between the control stage (master) and an SPR unit (slave).
// The signal names are the unit's own bus port names; the modports set the direction of each signal.
interface mor1kx_spr_sys_unit_if;
    logic [15:0] spr_bus_addr_i;
    logic        spr_bus_stb_i;
    logic        spr_bus_we_i;
    logic [31:0] spr_bus_dat_i;
    logic [31:0] spr_bus_dat_o;
    logic        spr_bus_ack_o;
    logic        spr_bus_err_o;

    modport master (
        output spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i,
        input  spr_bus_dat_o, spr_bus_ack_o, spr_bus_err_o
    );

    modport slave (
        input  spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i,
        output spr_bus_dat_o, spr_bus_ack_o, spr_bus_err_o
    );
endinterface

// File: rtl/mor1kx_spr_sys_unit.sv
// SPR group-0 unit: config-word readback plus EVBAR/AECR/AESR, one-cycle registered ack.
// Optional macro MOR1KX_SPR_SYS_ADDR_ERR_EN flags unimplemented indices on spr_bus_err_o.
module mor1kx_spr_sys_unit #(
    parameter string       FEATURE_EVBAR      = "NONE",
    parameter string       FEATURE_AECSR      = "NONE",
    parameter logic [31:0] OPTION_EVBAR_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    mor1kx_spr_sys_unit_if.slave spr_bus,
    input  logic [31:0] spr_vr_i,
    input  logic [31:0] spr_upr_i,
    input  logic [31:0] spr_cpucfgr_i,
    input  logic [31:0] spr_dmmucfgr_i,
    input  logic [31:0] spr_immucfgr_i,
    input  logic [31:0] spr_dccfgr_i,
    input  logic [31:0] spr_iccfgr_i,
    input  logic [31:0] spr_dcfgr_i,
    input  logic [31:0] spr_pccfgr_i,
    input  logic [31:0] spr_vr2_i,
    input  logic [31:0] spr_avr_i,
    input  logic [31:0] spr_fpcsr_i,
    input  logic [31:0] aesr_set_i,
    output logic [31:0] evbar_o,
    output logic [31:0] aecr_o,
    output logic [31:0] aesr_o
);
    localparam bit          EVBAR_EN   = (FEATURE_EVBAR == "ENABLED");
    localparam bit          AECSR_EN   = (FEATURE_AECSR == "ENABLED");
    localparam logic [31:0] EVBAR_MASK = ~32'h1fff;

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t      r_state, w_state_nxt;
    logic        w_ack, w_accept, w_wr, w_sel, w_err_acc;
    logic [10:0] w_idx;
    logic [31:0] w_rdata;
    logic [31:0] r_dat, r_evbar, r_aecr, r_aesr;

    assign w_idx = spr_bus.spr_bus_addr_i[10:0];
    assign w_sel = spr_bus.spr_bus_stb_i && (spr_bus.spr_bus_addr_i[15:11] == 5'd0);
    assign w_wr  = w_accept && spr_bus.spr_bus_we_i;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // stb is only looked at in IDLE; the ACK cycle is unconditional
    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: if (w_sel) begin
                w_accept    = 1'b1;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_ack       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = 32'h0;
        case (w_idx)
            11'd0:   w_rdata = spr_vr_i;
            11'd1:   w_rdata = spr_upr_i;
            11'd2:   w_rdata = spr_cpucfgr_i;
            11'd3:   w_rdata = spr_dmmucfgr_i;
            11'd4:   w_rdata = spr_immucfgr_i;
            11'd5:   w_rdata = spr_dccfgr_i;
            11'd6:   w_rdata = spr_iccfgr_i;
            11'd7:   w_rdata = spr_dcfgr_i;
            11'd8:   w_rdata = spr_pccfgr_i;
            11'd9:   w_rdata = spr_vr2_i;
            11'd10:  w_rdata = spr_avr_i;
            11'd11:  w_rdata = r_evbar;
            11'd12:  w_rdata = r_aecr;
            11'd13:  w_rdata = r_aesr;
            11'd20:  w_rdata = spr_fpcsr_i;
            default: w_rdata = 32'h0;
        endcase
    end

`ifdef MOR1KX_SPR_SYS_ADDR_ERR_EN
    logic w_impl;
    logic r_err;
    assign w_impl    = (w_idx <= 11'd13) || (w_idx == 11'd20);
    assign w_err_acc = !w_impl;

    always_ff @(posedge clk) begin
        if (rst)           r_err <= 1'b0;
        else if (w_accept) r_err <= w_err_acc;
    end
    assign spr_bus.spr_bus_err_o = w_ack && r_err;
`else
    assign w_err_acc             = 1'b0;
    assign spr_bus.spr_bus_err_o = 1'b0;
`endif

    // dat_o is the pre-write value of the register; it only moves on an accepted access
    always_ff @(posedge clk) begin
        if (rst)           r_dat <= 32'h0;
        else if (w_accept) r_dat <= w_err_acc ? 32'h0 : w_rdata;
    end

    generate
        if (EVBAR_EN) begin : g_evbar
            always_ff @(posedge clk) begin
                if (rst)                          r_evbar <= OPTION_EVBAR_RESET & EVBAR_MASK;
                else if (w_wr && w_idx == 11'd11) r_evbar <= spr_bus.spr_bus_dat_i & EVBAR_MASK;
            end
        end else begin : g_no_evbar
            always_ff @(posedge clk) r_evbar <= 32'h0;
        end

        if (AECSR_EN) begin : g_aecsr
            always_ff @(posedge clk) begin
                if (rst)                          r_aecr <= 32'h0;
                else if (w_wr && w_idx == 11'd12) r_aecr <= spr_bus.spr_bus_dat_i;
            end
            // status bits are sticky; a concurrent set pulse survives a bus write
            always_ff @(posedge clk) begin
                if (rst)                          r_aesr <= 32'h0;
                else if (w_wr && w_idx == 11'd13) r_aesr <= spr_bus.spr_bus_dat_i | aesr_set_i;
                else                              r_aesr <= r_aesr | aesr_set_i;
            end
        end else begin : g_no_aecsr
            logic w_unused_aesr_set;
            assign w_unused_aesr_set = ^aesr_set_i;
            always_ff @(posedge clk) begin
                r_aecr <= 32'h0;
                r_aesr <= 32'h0;
            end
        end
    endgenerate

    assign spr_bus.spr_bus_dat_o = r_dat;
    assign spr_bus.spr_bus_ack_o = w_ack;
    assign evbar_o               = r_evbar;
    assign aecr_o                = r_aecr;
    assign aesr_o                = r_aesr;
endmodule
